// File: rtl/dbf_ctrl_pkg.sv
// Shared types and constants for the DBF scanline controller and the channel bank.
// Holds the sequencer state enumeration and the phase-counter width helper.
package dbf_ctrl_pkg;

   localparam int DefAddrWd     = 10;
   localparam int DefDepth      = 1024;
   localparam int DefTxCycles   = 64;
   localparam int DefDeadCycles = 32;
   localparam int DefPipeLat    = 4;
   localparam int DefLineWd     = 8;

   typedef enum logic [2:0] {
      StIdle,
      StTx,
      StDead,
      StRx,
      StDrain,
      StDone
   } scanState_e;

   // A phase of length N reloads with N-1, so clog2 of the longest phase is enough;
   // the floor of one bit keeps the counter legal when every phase is a single cycle.
   function automatic int phaseCntWd(input int txCycles, input int deadCycles,
                                     input int depth, input int pipeLat);
      int longest;
      longest = txCycles;
      if (deadCycles > longest) longest = deadCycles;
      if (depth > longest) longest = depth;
      if (pipeLat > longest) longest = pipeLat;
      return (longest > 1) ? $clog2(longest) : 1;
   endfunction

endpackage

// File: rtl/dbf_scan_ctrl_if.sv
// Request/status and channel-control bus between the scan FSM, the sequencer and the channel bank.
// The master modport belongs to the requester; the slave modport belongs to dbf_scan_ctrl.
interface dbf_scan_ctrl_if #(
   parameter int LINE_WD = 8,
   parameter int ADDR_WD = 10
);

   logic               scan_req;
   logic [LINE_WD-1:0] line_sel;
   logic               abort;
   logic               scan_ack;
   logic               busy;
   logic [LINE_WD-1:0] line_idx;
   logic               tx_en;
   logic               start;
   logic [ADDR_WD-1:0] dbf_lut_addr;
   logic               dbf_lut_we;
   logic               line_done;
   logic               line_aborted;

   modport master (
      output scan_req, line_sel, abort,
      input  scan_ack, busy, line_idx, tx_en, start,
      input  dbf_lut_addr, dbf_lut_we, line_done, line_aborted
   );

   modport slave (
      input  scan_req, line_sel, abort,
      output scan_ack, busy, line_idx, tx_en, start,
      output dbf_lut_addr, dbf_lut_we, line_done, line_aborted
   );

endinterface

// File: rtl/dbf_phase_timer.sv
// Loadable down-counter that times every sequencer phase; zero_o marks the last cycle of a phase.
module dbf_phase_timer #(
   parameter int CNT_WD = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [CNT_WD-1:0] loadVal_i,
   output logic              zero_o
);

   logic [CNT_WD-1:0] count_q;
   logic [CNT_WD-1:0] count_d;

   // Saturate at zero so an unloaded timer simply reports the end of phase.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = loadVal_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/dbf_scan_ctrl.sv
// Per-scanline sequencer: IDLE -> TX -> DEAD -> RX -> DRAIN -> DONE, all outputs registered.
// Build macro DBF_ABORT_EN adds abort handling and the line_aborted pulse.
module dbf_scan_ctrl
   import dbf_ctrl_pkg::*;
#(
   parameter int ADDR_WD     = DefAddrWd,
   parameter int DEPTH       = DefDepth,
   parameter int TX_CYCLES   = DefTxCycles,
   parameter int DEAD_CYCLES = DefDeadCycles,
   parameter int PIPE_LAT    = DefPipeLat,
   parameter int LINE_WD     = DefLineWd
) (
   input logic            clk,
   input logic            rst,
   dbf_scan_ctrl_if.slave bus
);

   localparam int CNT_WD = phaseCntWd(TX_CYCLES, DEAD_CYCLES, DEPTH, PIPE_LAT);

   localparam logic [CNT_WD-1:0] TxLoad    = CNT_WD'(TX_CYCLES - 1);
   localparam logic [CNT_WD-1:0] DeadLoad  = CNT_WD'(DEAD_CYCLES - 1);
   localparam logic [CNT_WD-1:0] RxLoad    = CNT_WD'(DEPTH - 1);
   localparam logic [CNT_WD-1:0] DrainLoad = CNT_WD'(PIPE_LAT - 1);

   scanState_e         state_q;
   scanState_e         state_d;
   logic               timerLoad;
   logic               timerZero;
   logic [CNT_WD-1:0]  timerLoadVal;

   logic               scanAck_q,   scanAck_d;
   logic               busy_q,      busy_d;
   logic [LINE_WD-1:0] lineIdx_q,   lineIdx_d;
   logic               txEn_q,      txEn_d;
   logic               start_q,     start_d;
   logic [ADDR_WD-1:0] lutAddr_q,   lutAddr_d;
   logic               lutWe_q,     lutWe_d;
   logic               lineDone_q,  lineDone_d;
`ifdef DBF_ABORT_EN
   logic               abortHit;
   logic               lineAborted_q;
`endif

   dbf_phase_timer #(
      .CNT_WD (CNT_WD)
   ) u_phaseTimer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (timerLoad),
      .loadVal_i (timerLoadVal),
      .zero_o    (timerZero)
   );

   // Next state, timer reload on every state change, and the registered output values.
   always_comb begin
      state_d      = state_q;
      timerLoadVal = '0;

      unique case (state_q)
         StIdle:  if (bus.scan_req) state_d = StTx;
         StTx:    if (timerZero) state_d = StDead;
         StDead:  if (timerZero) state_d = StRx;
         StRx:    if (timerZero) state_d = StDrain;
         StDrain: if (timerZero) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

`ifdef DBF_ABORT_EN
      // DONE is excluded so a completed line always reports line_done.
      abortHit = 1'b0;
      if (bus.abort && (state_q != StIdle) && (state_q != StDone)) begin
         abortHit = 1'b1;
         state_d  = StIdle;
      end
`endif

      case (state_d)
         StTx:    timerLoadVal = TxLoad;
         StDead:  timerLoadVal = DeadLoad;
         StRx:    timerLoadVal = RxLoad;
         StDrain: timerLoadVal = DrainLoad;
         default: timerLoadVal = '0;
      endcase
      timerLoad = (state_d != state_q);

      scanAck_d  = (state_q == StIdle) && (state_d == StTx);
      lineIdx_d  = scanAck_d ? bus.line_sel : lineIdx_q;
      busy_d     = (state_d != StIdle);
      txEn_d     = (state_d == StTx);
      start_d    = (state_d == StRx) || (state_d == StDrain);
      lutWe_d    = (state_d == StRx);
      lineDone_d = (state_d == StDone);

      // The address only advances while staying in RX, so DEPTH-1 is held into DRAIN without wrapping.
      if (state_d == StRx) begin
         lutAddr_d = (state_q == StRx) ? lutAddr_q + 1'b1 : '0;
      end else if (state_d == StDrain) begin
         lutAddr_d = lutAddr_q;
      end else begin
         lutAddr_d = '0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         scanAck_q  <= 1'b0;
         busy_q     <= 1'b0;
         lineIdx_q  <= '0;
         txEn_q     <= 1'b0;
         start_q    <= 1'b0;
         lutAddr_q  <= '0;
         lutWe_q    <= 1'b0;
         lineDone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         scanAck_q  <= scanAck_d;
         busy_q     <= busy_d;
         lineIdx_q  <= lineIdx_d;
         txEn_q     <= txEn_d;
         start_q    <= start_d;
         lutAddr_q  <= lutAddr_d;
         lutWe_q    <= lutWe_d;
         lineDone_q <= lineDone_d;
      end
   end

`ifdef DBF_ABORT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         lineAborted_q <= 1'b0;
      end else begin
         lineAborted_q <= abortHit;
      end
   end

   assign bus.line_aborted = lineAborted_q;
`else
   logic unusedAbort;
   assign unusedAbort      = bus.abort;
   assign bus.line_aborted = 1'b0;
`endif

   assign bus.scan_ack     = scanAck_q;
   assign bus.busy         = busy_q;
   assign bus.line_idx     = lineIdx_q;
   assign bus.tx_en        = txEn_q;
   assign bus.start        = start_q;
   assign bus.dbf_lut_addr = lutAddr_q;
   assign bus.dbf_lut_we   = lutWe_q;
   assign bus.line_done    = lineDone_q;

endmodule
